// File: rtl/output_readback_dma.sv
`default_nettype none
// ============================================================================
// Module   : output_readback_dma
// Purpose  : Read-side master for the output memory CPU/DMA read port. Once
//            the engine has finished, it streams a programmed window of result
//            words out on a valid/ready bus. Reads are issued against a
//            credit count, so backpressure from the sink throttles the read
//            port and the small output FIFO can never overflow.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start, base_addr,   - transfer launch pulse plus window,
//            len                   sampled together with start
//            busy, done, err     - status (done/err are 1-cycle pulses)
//            mem_rd_addr/en      - to output memory cpu_rd_addr / cpu_rd_en
//            mem_rd_data         - from output memory, valid 1 cycle after en
//            m_valid, m_ready,   - result stream (first-word fall-through)
//            m_data, m_last
//            checksum            - running sum of streamed words
// Options  : OUT_RD_CHECKSUM_EN - when defined, checksum accumulates every
//            streamed word; when undefined, checksum is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module output_readback_dma #(
    parameter int DEPTH      = 301056,
    parameter int AW         = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_rd_addr,
    output logic          mem_rd_en,
    input  logic [31:0]   mem_rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic          m_last,
    output logic [31:0]   checksum
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [AW:0]     c_DEPTH_X   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   c_ONE       = AW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW:0]   c_FIFO_LIM  = (c_CW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [AW-1:0]   r_base;
    logic [AW-1:0]   r_len;
    logic [AW-1:0]   r_issued;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_addr;
    logic            r_rd_last;     // tag of the read on the port this cycle
    logic            r_pend;        // read data arriving on mem_rd_data now
    logic            r_pend_last;

    logic [31:0]     r_fifo_data [FIFO_DEPTH];
    logic            r_fifo_last [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_head_last;
    logic [c_CW:0]   w_used;
    logic            w_issue;
    logic [AW:0]     w_sum_end;
    logic            w_range_bad;
    logic            w_accept;

    assign w_empty     = (r_count == '0);
    assign w_pop       = !w_empty && m_ready;
    assign w_push      = r_pend;
    assign w_head_last = r_fifo_last[r_rd_ptr];

    // Credits: FIFO occupancy plus both pipeline stages of reads not yet
    // pushed (one on the port, one returning). Keeping the sum below
    // FIFO_DEPTH means every issued read has a guaranteed slot.
    assign w_used  = {1'b0, r_count} + (c_CW+1)'(r_rd_en) + (c_CW+1)'(r_pend);
    assign w_issue = (r_state == c_RUN) && (r_issued != r_len) && (w_used < c_FIFO_LIM);

    // One extra bit so base+len cannot wrap when checking the window.
    assign w_sum_end   = {1'b0, base_addr} + {1'b0, len};
    assign w_range_bad = (w_sum_end > c_DEPTH_X);
    assign w_accept    = (r_state == c_IDLE) && start && (len != '0) && !w_range_bad;

    // ------------------------------------------------------------------
    // Control FSM and read issue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_last   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= w_issue;
            r_pend      <= r_rd_en;
            r_pend_last <= r_rd_last;

            if (w_issue) begin
                r_rd_addr <= r_base + r_issued;
                r_rd_last <= (r_issued == (r_len - c_ONE));
                r_issued  <= r_issued + c_ONE;
            end

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            r_done <= 1'b1;
                        end else if (w_range_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_base   <= base_addr;
                            r_len    <= len;
                            r_issued <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    if (r_issued == r_len) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // Only the tagged final word can satisfy this, so done
                    // lands exactly one cycle after its handshake.
                    if (w_pop && w_head_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rd_data;
            r_fifo_last[r_wr_ptr] <= r_pend_last;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign m_valid     = !w_empty;
    // Gated so stale storage never shows on the bus when nothing is valid.
    assign m_data      = w_empty ? 32'd0 : r_fifo_data[r_rd_ptr];
    assign m_last      = !w_empty && w_head_last;

`ifdef OUT_RD_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + m_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_output_readback_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_readback_dma
// Purpose  : Directed self-checking bench for output_readback_dma with a
//            1-cycle registered memory model (mem[i] = i, or all-ones).
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_readback_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [18:0] base_addr = '0;
    logic [18:0] len = '0;
    logic        busy, done, err;
    logic [18:0] mem_rd_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_last;
    logic [31:0] checksum;

    output_readback_dma dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    // Memory model
    logic fill = 1'b0;
    function automatic logic [31:0] word(input logic [18:0] a);
        return fill ? 32'hFFFF_FFFF : {13'd0, a};
    endfunction
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= word(mem_rd_addr);

    int n_cmp = 0;
    int n_bad = 0;

    // Observation state, all written by the single stimulus thread
    int          cyc = 0;
    logic [31:0] hs_data [$];
    logic        hs_last [$];
    int          hs_cyc  [$];
    int          hs_total, rd_total, max_out, stab_err;
    int          done_cnt, done_cyc, err_cnt, err_cyc, both_cnt;
    int          busy_seen, valid_seen, start_cyc;
    logic        stall_pend;
    logic [31:0] stall_data;
    logic        stall_last;
    logic        toggle = 1'b0;

    task automatic clear_mon();
        hs_data.delete(); hs_last.delete(); hs_cyc.delete();
        hs_total = 0; rd_total = 0; max_out = 0; stab_err = 0;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1; both_cnt = 0;
        busy_seen = 0; valid_seen = 0; start_cyc = -1; stall_pend = 1'b0;
    endtask

    // Sample at negedge, then advance to just after the next posedge
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_rd_en) begin
            if (rd_total + 1 - hs_total > max_out) max_out = rd_total + 1 - hs_total;
            rd_total++;
        end
        if (stall_pend && (!m_valid || m_data !== stall_data || m_last !== stall_last)) stab_err++;
        stall_pend = m_valid && !m_ready;
        stall_data = m_data;
        stall_last = m_last;
        if (m_valid && m_ready) begin
            hs_data.push_back(m_data); hs_last.push_back(m_last); hs_cyc.push_back(cyc);
            hs_total++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (done && err) both_cnt++;
        if (busy) busy_seen++;
        if (m_valid) valid_seen++;
        if (start && !busy && start_cyc < 0) start_cyc = cyc;
        @(posedge clk);
        #1;
        if (toggle) m_ready = !m_ready;
    endtask

    task automatic pulse_start(input logic [18:0] b, input logic [18:0] l);
        start = 1'b1; base_addr = b; len = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin step(); n++; end
        n_cmp++;
        if (done_cnt == 0) begin
            n_bad++;
            $display("FAIL %s_timeout: no done within %0d cycles (required done)", name, budget);
        end
        step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_cmp++;
        if ({busy, done, err, mem_rd_en, m_valid, m_last} !== 6'b0 || mem_rd_addr !== '0 ||
            m_data !== '0 || checksum !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b en=%b addr=%0d valid=%b data=%h last=%b sum=%h (required all 0)",
                     busy, done, err, mem_rd_en, mem_rd_addr, m_valid, m_data, m_last, checksum);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        clear_mon(); m_ready = 1'b1; toggle = 1'b0;
        pulse_start(19'd0, 19'd8);
        wait_done(100, "basic");
        n_cmp++;
        if (hs_total !== 8) begin n_bad++; $display("FAIL basic_count: got %0d words, required 8", hs_total); end
        for (int k = 0; k < hs_total && k < 8; k++) begin
            n_cmp++;
            if (hs_data[k] !== 32'(k) || hs_last[k] !== (k == 7) || hs_cyc[k] !== hs_cyc[0] + k) begin
                n_bad++;
                $display("FAIL basic_word%0d: data=%0d last=%b cyc=%0d, required data=%0d last=%b cyc=%0d",
                         k, hs_data[k], hs_last[k], hs_cyc[k], k, (k == 7), hs_cyc[0] + k);
            end
        end
        n_cmp++;
        if (hs_total == 8 && done_cyc !== hs_cyc[7] + 1) begin
            n_bad++; $display("FAIL basic_done_timing: done cycle %0d, required %0d", done_cyc, hs_cyc[7] + 1);
        end
        n_cmp++;
        if (rd_total !== 8 || done_cnt !== 1 || busy !== 1'b0 || err_cnt !== 0 || both_cnt !== 0) begin
            n_bad++;
            $display("FAIL basic_status: reads=%0d dones=%0d busy=%b errs=%0d (required 8,1,0,0)",
                     rd_total, done_cnt, busy, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        clear_mon(); m_ready = 1'b1; toggle = 1'b1;
        pulse_start(19'd100, 19'd16);
        wait_done(300, "bp");
        toggle = 1'b0; m_ready = 1'b1;
        n_cmp++;
        if (hs_total !== 16) begin n_bad++; $display("FAIL bp_count: got %0d words, required 16", hs_total); end
        for (int k = 0; k < hs_total && k < 16; k++) begin
            n_cmp++;
            if (hs_data[k] !== 32'(100 + k) || hs_last[k] !== (k == 15)) begin
                n_bad++;
                $display("FAIL bp_word%0d: data=%0d last=%b, required data=%0d last=%b",
                         k, hs_data[k], hs_last[k], 100 + k, (k == 15));
            end
        end
        n_cmp++;
        if (max_out !== 4) begin n_bad++; $display("FAIL bp_credit: peak outstanding %0d, required 4", max_out); end
        n_cmp++;
        if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stable: %0d stalled words changed, required 0", stab_err); end
        n_cmp++;
        if (rd_total !== 16) begin n_bad++; $display("FAIL bp_reads: %0d reads, required 16", rd_total); end
    endtask

    task automatic test_boundary();
        clear_mon(); m_ready = 1'b1;
        pulse_start(19'd301050, 19'd6);
        wait_done(100, "edge_ok");
        n_cmp++;
        if (hs_total !== 6 || err_cnt !== 0) begin
            n_bad++; $display("FAIL edge_ok_count: words=%0d errs=%0d, required 6,0", hs_total, err_cnt);
        end
        for (int k = 0; k < hs_total && k < 6; k++) begin
            n_cmp++;
            if (hs_data[k] !== 32'(301050 + k)) begin
                n_bad++; $display("FAIL edge_ok_word%0d: data=%0d, required %0d", k, hs_data[k], 301050 + k);
            end
        end
        clear_mon();
        pulse_start(19'd301050, 19'd7);
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (err_cnt !== 1 || err_cyc !== start_cyc + 1) begin
            n_bad++; $display("FAIL edge_err_pulse: errs=%0d at cyc %0d, required 1 at %0d", err_cnt, err_cyc, start_cyc + 1);
        end
        n_cmp++;
        if (rd_total !== 0 || busy_seen !== 0 || done_cnt !== 0 || valid_seen !== 0) begin
            n_bad++;
            $display("FAIL edge_err_quiet: reads=%0d busy_cycles=%0d dones=%0d valid_cycles=%0d (required all 0)",
                     rd_total, busy_seen, done_cnt, valid_seen);
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        pulse_start(19'd5, 19'd0);
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== start_cyc + 1 || err_cnt !== 0) begin
            n_bad++;
            $display("FAIL zero_done: dones=%0d at cyc %0d errs=%0d, required 1 at %0d, 0 errs",
                     done_cnt, done_cyc, err_cnt, start_cyc + 1);
        end
        n_cmp++;
        if (rd_total !== 0 || valid_seen !== 0 || busy_seen !== 0) begin
            n_bad++; $display("FAIL zero_quiet: reads=%0d valid=%0d busy=%0d, required 0", rd_total, valid_seen, busy_seen);
        end
    endtask

    task automatic test_start_while_busy();
        clear_mon(); m_ready = 1'b1;
        pulse_start(19'd0, 19'd8);
        step(); step();
        pulse_start(19'd500, 19'd3);
        wait_done(100, "busy_start");
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (hs_total !== 8 || done_cnt !== 1 || err_cnt !== 0 || rd_total !== 8) begin
            n_bad++;
            $display("FAIL busy_start_status: words=%0d dones=%0d errs=%0d reads=%0d, required 8,1,0,8",
                     hs_total, done_cnt, err_cnt, rd_total);
        end
        for (int k = 0; k < hs_total && k < 8; k++) begin
            n_cmp++;
            if (hs_data[k] !== 32'(k)) begin
                n_bad++; $display("FAIL busy_start_word%0d: data=%0d, required %0d", k, hs_data[k], k);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon(); m_ready = 1'b1;
        pulse_start(19'd200, 19'd10);
        while (hs_total < 3 && n < 50) begin step(); n++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, err, mem_rd_en, m_valid, m_last} !== 6'b0 || mem_rd_addr !== '0 ||
            m_data !== '0 || checksum !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: busy=%b done=%b err=%b en=%b addr=%0d valid=%b data=%h last=%b sum=%h (required all 0)",
                     busy, done, err, mem_rd_en, mem_rd_addr, m_valid, m_data, m_last, checksum);
        end
        clear_mon();
        for (int i = 0; i < 15; i++) step();
        n_cmp++;
        if (done_cnt !== 0 || valid_seen !== 0 || rd_total !== 0) begin
            n_bad++; $display("FAIL midrst_aborted: dones=%0d valid=%0d reads=%0d, required 0", done_cnt, valid_seen, rd_total);
        end
        pulse_start(19'd0, 19'd2);
        wait_done(50, "midrst_restart");
        n_cmp++;
        if (hs_total !== 2 || hs_data[0] !== 32'd0 || hs_data[1] !== 32'd1 || hs_last[1] !== 1'b1) begin
            n_bad++; $display("FAIL midrst_restart: words=%0d, required 2 words 0,1 with last on 1", hs_total);
        end
    endtask

    task automatic test_checksum();
        clear_mon(); m_ready = 1'b1; fill = 1'b1;
        pulse_start(19'd10, 19'd2);
        wait_done(50, "csum");
        fill = 1'b0;
`ifdef OUT_RD_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL csum_value: checksum=%h, required fffffffe", checksum);
        end
        clear_mon();
        pulse_start(19'd0, 19'd4);
        n_cmp++;
        if (checksum !== 32'd0) begin
            n_bad++; $display("FAIL csum_clear: checksum=%h after start, required 0", checksum);
        end
        wait_done(50, "csum2");
        n_cmp++;
        if (checksum !== 32'd6) begin
            n_bad++; $display("FAIL csum_second: checksum=%h, required 6", checksum);
        end
`else
        n_cmp++;
        if (checksum !== 32'd0) begin
            n_bad++; $display("FAIL csum_tied: checksum=%h, required 0", checksum);
        end
`endif
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_boundary();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
